// File: rtl/id_operand_fetch_if.sv
// Bundle of IF->ID, register-file read, write-back snoop and ID->EX signals.
// The stage uses the slave modport; the surrounding core uses the master modport.
interface id_operand_fetch_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic [XLEN-1:0] IF_ID_PC;
  logic [31:0]     IF_ID_IR;
  logic            IF_ID_VALID;
  logic            ID_READY;
  logic            RF_RE;
  logic [RA_W-1:0] RF_RA;
  logic [XLEN-1:0] RF_RD;
  logic            WB_WE;
  logic [RA_W-1:0] WB_ADDR;
  logic [XLEN-1:0] WB_DATA;
  logic [XLEN-1:0] ID_EX_PC;
  logic [31:0]     ID_EX_IR;
  logic [XLEN-1:0] ID_EX_A;
  logic [XLEN-1:0] ID_EX_B;
  logic [XLEN-1:0] ID_EX_IMM;
  logic            ID_EX_ILLEGAL;
  logic            ID_EX_VALID;
  logic            EX_READY;

  modport slave (
    input  IF_ID_PC, IF_ID_IR, IF_ID_VALID, RF_RD, WB_WE, WB_ADDR, WB_DATA, EX_READY,
    output ID_READY, RF_RE, RF_RA, ID_EX_PC, ID_EX_IR, ID_EX_A, ID_EX_B, ID_EX_IMM,
           ID_EX_ILLEGAL, ID_EX_VALID
  );

  modport master (
    output IF_ID_PC, IF_ID_IR, IF_ID_VALID, RF_RD, WB_WE, WB_ADDR, WB_DATA, EX_READY,
    input  ID_READY, RF_RE, RF_RA, ID_EX_PC, ID_EX_IR, ID_EX_A, ID_EX_B, ID_EX_IMM,
           ID_EX_ILLEGAL, ID_EX_VALID
  );
endinterface

// File: rtl/id_operand_fetch.sv
// Decode / operand-read stage: decodes one instruction, reads rs1/rs2 through the
// single registered register-file port with write-back forwarding, and hands off to EX.
module id_operand_fetch #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  id_operand_fetch_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IDLE, RD1, RD2, CAPT, OUT} state_t;

  state_t          state_q, state_d;
  logic            need_rs1_q, need_rs2_q;
  logic            rd_pend_q;
  logic            fwd_hit_q;
  logic [XLEN-1:0] fwd_data_q;

  logic            dec_need_rs1, dec_need_rs2, dec_illegal;
  logic [XLEN-1:0] dec_imm;
  logic            accept;
  logic [RA_W-1:0] rs1, rs2;
  logic            wb_hit_a, wb_hit_b;
  logic            rf_re_d, id_ready_d, valid_d;
  logic [RA_W-1:0] rf_ra_d;
  logic [XLEN-1:0] opnd_a, opnd_b;

  assign accept = (state_q == IDLE) && bus.IF_ID_VALID && bus.ID_READY;
  assign rs1    = RA_W'(bus.ID_EX_IR[19:15]);
  assign rs2    = RA_W'(bus.ID_EX_IR[24:20]);

  // Format decode and immediate generation on the offered instruction
  always_comb begin
    dec_need_rs1 = 1'b0;
    dec_need_rs2 = 1'b0;
    dec_illegal  = 1'b0;
    dec_imm      = '0;
    case (bus.IF_ID_IR[6:0])
      OP_R: begin
        dec_need_rs1 = 1'b1;
        dec_need_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_need_rs1 = 1'b1;
        dec_imm      = XLEN'($signed(bus.IF_ID_IR[31:20]));
      end
      OP_STORE: begin
        dec_need_rs1 = 1'b1;
        dec_need_rs2 = 1'b1;
        dec_imm      = XLEN'($signed({bus.IF_ID_IR[31:25], bus.IF_ID_IR[11:7]}));
      end
      OP_BRANCH: begin
        dec_need_rs1 = 1'b1;
        dec_need_rs2 = 1'b1;
        dec_imm      = XLEN'($signed({bus.IF_ID_IR[31], bus.IF_ID_IR[7],
                                      bus.IF_ID_IR[30:25], bus.IF_ID_IR[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: dec_imm = XLEN'($signed({bus.IF_ID_IR[31:12], 12'b0}));
      OP_JAL: dec_imm = XLEN'($signed({bus.IF_ID_IR[31], bus.IF_ID_IR[19:12],
                                        bus.IF_ID_IR[20], bus.IF_ID_IR[30:21], 1'b0}));
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = CAPT;
      CAPT:    state_d = OUT;
      OUT:     if (bus.EX_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wb_hit_a = bus.WB_WE && need_rs1_q && (rs1 != '0) && (bus.WB_ADDR == rs1);
  assign wb_hit_b = bus.WB_WE && need_rs2_q && (rs2 != '0) && (bus.WB_ADDR == rs2);

  // Next values of registered outputs; a capture-cycle write beats an issue-cycle one
  always_comb begin
    rf_re_d    = 1'b0;
    rf_ra_d    = '0;
    id_ready_d = (state_d == IDLE);
    valid_d    = (state_d == OUT);
    opnd_a     = '0;
    opnd_b     = '0;
    if (wb_hit_a)       opnd_a = bus.WB_DATA;
    else if (fwd_hit_q) opnd_a = fwd_data_q;
    else if (rd_pend_q) opnd_a = bus.RF_RD;
    if (wb_hit_b)       opnd_b = bus.WB_DATA;
    else if (fwd_hit_q) opnd_b = fwd_data_q;
    else if (rd_pend_q) opnd_b = bus.RF_RD;
    case (state_q)
      IDLE: if (accept && dec_need_rs1 && (bus.IF_ID_IR[19:15] != 5'd0)) begin
        rf_re_d = 1'b1;
        rf_ra_d = RA_W'(bus.IF_ID_IR[19:15]);
      end
      RD1: if (need_rs2_q && (rs2 != '0)) begin
        rf_re_d = 1'b1;
        rf_ra_d = rs2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ID_READY      <= 1'b1;
      bus.RF_RE         <= 1'b0;
      bus.RF_RA         <= '0;
      bus.ID_EX_PC      <= '0;
      bus.ID_EX_IR      <= '0;
      bus.ID_EX_A       <= '0;
      bus.ID_EX_B       <= '0;
      bus.ID_EX_IMM     <= '0;
      bus.ID_EX_ILLEGAL <= 1'b0;
      bus.ID_EX_VALID   <= 1'b0;
      need_rs1_q        <= 1'b0;
      need_rs2_q        <= 1'b0;
      rd_pend_q         <= 1'b0;
      fwd_hit_q         <= 1'b0;
      fwd_data_q        <= '0;
    end else begin
      bus.ID_READY    <= id_ready_d;
      bus.RF_RE       <= rf_re_d;
      bus.RF_RA       <= rf_ra_d;
      bus.ID_EX_VALID <= valid_d;
      rd_pend_q       <= bus.RF_RE;
      case (state_q)
        IDLE: if (accept) begin
          bus.ID_EX_PC      <= bus.IF_ID_PC;
          bus.ID_EX_IR      <= bus.IF_ID_IR;
          bus.ID_EX_IMM     <= dec_imm;
          bus.ID_EX_ILLEGAL <= dec_illegal;
          need_rs1_q        <= dec_need_rs1;
          need_rs2_q        <= dec_need_rs2;
          fwd_hit_q         <= 1'b0;
        end
        RD1: begin
          fwd_hit_q  <= wb_hit_a;
          fwd_data_q <= bus.WB_DATA;
        end
        RD2: begin
          bus.ID_EX_A <= opnd_a;
          fwd_hit_q   <= wb_hit_b;
          fwd_data_q  <= bus.WB_DATA;
        end
        CAPT: bus.ID_EX_B <= opnd_b;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch with a register-file model and an
// expectation queue drained by an independent output monitor.
module tb_id_operand_fetch;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_operand_fetch_if #(.XLEN(XLEN), .RA_W(RA_W)) bus();
  id_operand_fetch #(.XLEN(XLEN), .RA_W(RA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic        wbp_en[1:3];
  logic [4:0]  wbp_addr[1:3];
  logic [31:0] wbp_data[1:3];

  logic [31:0] regs[32];

  // Register file model: one registered read port, write-back port
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[1] <= 32'd5;
      regs[2] <= 32'd7;
    end else if (bus.WB_WE && bus.WB_ADDR != 5'd0) begin
      regs[bus.WB_ADDR] <= bus.WB_DATA;
    end
    if (bus.RF_RE) bus.RF_RD <= regs[bus.RF_RA];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h want=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every EX handshake pops and checks one expected result
  always @(negedge clk) begin
    if (!rst && bus.ID_EX_VALID === 1'b1 && bus.EX_READY === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got=1 want=0 at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        chk("ex_pc",      bus.ID_EX_PC,  mon_e.pc);
        chk("ex_ir",      bus.ID_EX_IR,  mon_e.ir);
        chk("ex_a",       bus.ID_EX_A,   mon_e.a);
        chk("ex_b",       bus.ID_EX_B,   mon_e.b);
        chk("ex_imm",     bus.ID_EX_IMM, mon_e.imm);
        chk("ex_illegal", 32'(bus.ID_EX_ILLEGAL), 32'(mon_e.ill));
      end
    end
  end

  task automatic clear_wb_plan();
    for (int k = 1; k <= 3; k++) begin
      wbp_en[k]   = 1'b0;
      wbp_addr[k] = 5'd0;
      wbp_data[k] = 32'd0;
    end
  endtask

  task automatic run_txn(input logic [31:0] pc, input logic [31:0] ir,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic ill,
                         input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2,
                         input int stall);
    exp_t e;
    int   last;
    last = 4 + stall;
    @(negedge clk);
    chk("idle_ready", 32'(bus.ID_READY), 32'd1);
    e.pc = pc; e.ir = ir; e.a = a; e.b = b; e.imm = imm; e.ill = ill;
    sb.push_back(e);
    bus.IF_ID_PC    = pc;
    bus.IF_ID_IR    = ir;
    bus.IF_ID_VALID = 1'b1;
    bus.EX_READY    = (stall == 0);
    @(posedge clk); #1;
    // Keep offering junk while busy; the stage must ignore it
    bus.IF_ID_PC = 32'hDEAD_0000;
    bus.IF_ID_IR = 32'h0000_007F;
    for (int k = 1; k <= last; k++) begin
      if (k <= 3 && wbp_en[k]) begin
        bus.WB_WE   = 1'b1;
        bus.WB_ADDR = wbp_addr[k];
        bus.WB_DATA = wbp_data[k];
      end else begin
        bus.WB_WE = 1'b0;
      end
      if (k == 4) bus.IF_ID_VALID = 1'b0;
      if (k == last) bus.EX_READY = 1'b1;
      @(negedge clk);
      if (k == 1) begin
        chk("busy_ready", 32'(bus.ID_READY), 32'd0);
        chk("rd1_re", 32'(bus.RF_RE), 32'(re1));
        chk("rd1_ra", 32'(bus.RF_RA), re1 ? 32'(ra1) : 32'd0);
      end
      if (k == 2) begin
        chk("rd2_re", 32'(bus.RF_RE), 32'(re2));
        chk("rd2_ra", 32'(bus.RF_RA), re2 ? 32'(ra2) : 32'd0);
      end
      if (k == 3) begin
        chk("capt_valid", 32'(bus.ID_EX_VALID), 32'd0);
        chk("capt_re", 32'(bus.RF_RE), 32'd0);
      end
      if (k >= 4) chk("out_valid", 32'(bus.ID_EX_VALID), 32'd1);
      if (k >= 4 && k < last) begin
        chk("stall_ready", 32'(bus.ID_READY), 32'd0);
        chk("stall_a", bus.ID_EX_A, a);
        chk("stall_b", bus.ID_EX_B, b);
        chk("stall_ir", bus.ID_EX_IR, ir);
      end
      @(posedge clk); #1;
    end
    bus.WB_WE = 1'b0;
    @(negedge clk);
    chk("post_ready", 32'(bus.ID_READY), 32'd1);
    chk("post_valid", 32'(bus.ID_EX_VALID), 32'd0);
    clear_wb_plan();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.IF_ID_PC    = 32'd0;
    bus.IF_ID_IR    = 32'd0;
    bus.IF_ID_VALID = 1'b0;
    bus.WB_WE       = 1'b0;
    bus.WB_ADDR     = 5'd0;
    bus.WB_DATA     = 32'd0;
    bus.EX_READY    = 1'b1;
    clear_wb_plan();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ID_READY), 32'd1);
    chk("rst_re", 32'(bus.RF_RE), 32'd0);
    chk("rst_ra", 32'(bus.RF_RA), 32'd0);
    chk("rst_valid", 32'(bus.ID_EX_VALID), 32'd0);
    chk("rst_a", bus.ID_EX_A, 32'd0);
    chk("rst_imm", bus.ID_EX_IMM, 32'd0);

    // ADD x3,x1,x2
    run_txn(32'h100, 32'h002081B3, 32'd5, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 0);
    // ADDI x1,x0,-1: no reads
    run_txn(32'h104, 32'hFFF00093, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 0);
    // BEQ x1,x2,-4
    run_txn(32'h108, 32'hFE208EE3, 32'd5, 32'd7, 32'hFFFFFFFC, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 0);
    // Capture-cycle write-back of x1 (x1 becomes 0x55)
    wbp_en[2] = 1'b1; wbp_addr[2] = 5'd1; wbp_data[2] = 32'h55;
    run_txn(32'h10C, 32'h002081B3, 32'h55, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 0);
    // Issue-cycle write-back of x1 (read returns stale 0x55, x1 becomes 0x66)
    wbp_en[1] = 1'b1; wbp_addr[1] = 5'd1; wbp_data[1] = 32'h66;
    run_txn(32'h110, 32'h002081B3, 32'h66, 32'd7, 32'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 0);
    // x2 written in both issue and capture cycles: capture value wins
    wbp_en[2] = 1'b1; wbp_addr[2] = 5'd2; wbp_data[2] = 32'h33;
    wbp_en[3] = 1'b1; wbp_addr[3] = 5'd2; wbp_data[3] = 32'h44;
    run_txn(32'h114, 32'h002081B3, 32'h66, 32'h44, 32'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 0);
    // EX back-pressure for 3 cycles at OUT
    run_txn(32'h118, 32'h002081B3, 32'h66, 32'h44, 32'd0, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 3);
    // SW x2,-8(x1)
    run_txn(32'h11C, 32'hFE20AC23, 32'h66, 32'h44, 32'hFFFFFFF8, 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 0);
    // JAL x0,-2
    run_txn(32'h120, 32'hFFFFF06F, 32'd0, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 0);

    // Reset in the middle of a transaction (cycle T+2)
    @(negedge clk);
    bus.IF_ID_PC    = 32'h200;
    bus.IF_ID_IR    = 32'h002081B3;
    bus.IF_ID_VALID = 1'b1;
    @(posedge clk); #1;
    bus.IF_ID_VALID = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.ID_EX_VALID), 32'd0);
    chk("midrst_re", 32'(bus.RF_RE), 32'd0);
    chk("midrst_ready", 32'(bus.ID_READY), 32'd1);
    chk("midrst_a", bus.ID_EX_A, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(bus.ID_EX_VALID), 32'd0);
    end

    // Unsupported opcode still completes the handshake
    run_txn(32'h300, 32'h0000007F, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 0);
    // LUI x5,0x12345
    run_txn(32'h304, 32'h123452B7, 32'd0, 32'd0, 32'h12345000, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 0);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
